// File: rtl/id_branch_unit.sv
// Decode-stage branch resolution: operand forwarding, RV32 condition evaluation,
// 2-bit BHT prediction/training, registered mispredict redirect and perf counters.
module id_branch_unit #(
   parameter int XLEN      = 32,
   parameter int BHT_DEPTH = 16,
   parameter int CNT_W     = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  if_pc,
   output logic             if_pred_taken,
   input  logic             id_valid,
   input  logic             id_branch,
   input  logic [XLEN-1:0]  id_pc,
   input  logic [XLEN-1:0]  id_imm,
   input  logic             id_pred_taken,
   input  logic [2:0]       funct3,
   input  logic [XLEN-1:0]  rs1_data,
   input  logic [XLEN-1:0]  rs2_data,
   input  logic [1:0]       rs1_fwd,
   input  logic [1:0]       rs2_fwd,
   input  logic [XLEN-1:0]  ex_result,
   input  logic [XLEN-1:0]  mem_result,
   input  logic [XLEN-1:0]  wb_result,
   input  logic             ex_is_load,
   output logic             stall,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             illegal_branch,
   output logic [CNT_W-1:0] br_count,
   output logic [CNT_W-1:0] mispred_count
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [1:0]      bht [BHT_DEPTH];
   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] id_idx;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] target_pc;
   logic [XLEN-1:0] fall_pc;
   logic            taken;
   logic            legal;
   logic            resolve;
   logic            mispredict;
   logic [1:0]      bht_cur;
   logic [1:0]      bht_next;

   assign if_idx        = IDX_W'(if_pc >> 2);
   assign id_idx        = IDX_W'(id_pc >> 2);
   assign if_pred_taken = bht[if_idx][1];

   always_comb begin
      op_a = rs1_data;
      op_b = rs2_data;
      case (rs1_fwd)
         2'b01:   op_a = ex_result;
         2'b10:   op_a = mem_result;
         2'b11:   op_a = wb_result;
         default: op_a = rs1_data;
      endcase
      case (rs2_fwd)
         2'b01:   op_b = ex_result;
         2'b10:   op_b = mem_result;
         2'b11:   op_b = wb_result;
         default: op_b = rs2_data;
      endcase
   end

   // A load in EX cannot forward yet; a wrong-path instruction never stalls.
   assign stall = id_valid & id_branch & ex_is_load
                & ((rs1_fwd == 2'b01) | (rs2_fwd == 2'b01)) & ~redirect_valid;
   assign resolve    = id_valid & id_branch & ~stall & ~redirect_valid;
   assign legal      = (funct3[2:1] != 2'b01);
   assign target_pc  = id_pc + id_imm;
   assign fall_pc    = id_pc + XLEN'(4);
   assign mispredict = resolve & (taken != id_pred_taken);

   always_comb begin
      taken = 1'b0;
      case (funct3)
         3'b000:  taken = (op_a == op_b);
         3'b001:  taken = (op_a != op_b);
         3'b100:  taken = ($signed(op_a) < $signed(op_b));
         3'b101:  taken = ($signed(op_a) >= $signed(op_b));
         3'b110:  taken = (op_a < op_b);
         3'b111:  taken = (op_a >= op_b);
         default: taken = 1'b0;
      endcase
   end

   always_comb begin
      bht_cur  = bht[id_idx];
      bht_next = bht_cur;
      if (taken) begin
         if (bht_cur != 2'b11) bht_next = bht_cur + 2'd1;
      end else begin
         if (bht_cur != 2'b00) bht_next = bht_cur - 2'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < BHT_DEPTH; i++) bht[i] <= 2'b01;
      end else if (resolve && legal) begin
         bht[id_idx] <= bht_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         redirect_valid <= 1'b0;
         redirect_pc    <= '0;
         illegal_branch <= 1'b0;
         br_count       <= '0;
         mispred_count  <= '0;
      end else begin
         redirect_valid <= mispredict;
         illegal_branch <= resolve & ~legal;
         if (mispredict) redirect_pc <= taken ? target_pc : fall_pc;
         if (resolve && (br_count != '1)) br_count <= br_count + CNT_W'(1);
         if (mispredict && (mispred_count != '1)) mispred_count <= mispred_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_id_branch_unit.sv
// Directed self-checking bench for id_branch_unit with hand-computed expectations.
module tb_id_branch_unit;

   logic        clk;
   logic        rst_n;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic        id_valid;
   logic        id_branch;
   logic [31:0] id_pc;
   logic [31:0] id_imm;
   logic        id_pred_taken;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic [1:0]  rs1_fwd;
   logic [1:0]  rs2_fwd;
   logic [31:0] ex_result;
   logic [31:0] mem_result;
   logic [31:0] wb_result;
   logic        ex_is_load;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        illegal_branch;
   logic [31:0] br_count;
   logic [31:0] mispred_count;

   int vecCount = 0;
   int errCount = 0;
   int expBr    = 0;
   int expMis   = 0;

   id_branch_unit #(.XLEN(32), .BHT_DEPTH(16), .CNT_W(32)) dut (
      .clk(clk), .rst_n(rst_n), .if_pc(if_pc), .if_pred_taken(if_pred_taken),
      .id_valid(id_valid), .id_branch(id_branch), .id_pc(id_pc), .id_imm(id_imm),
      .id_pred_taken(id_pred_taken), .funct3(funct3), .rs1_data(rs1_data),
      .rs2_data(rs2_data), .rs1_fwd(rs1_fwd), .rs2_fwd(rs2_fwd),
      .ex_result(ex_result), .mem_result(mem_result), .wb_result(wb_result),
      .ex_is_load(ex_is_load), .stall(stall), .redirect_valid(redirect_valid),
      .redirect_pc(redirect_pc), .illegal_branch(illegal_branch),
      .br_count(br_count), .mispred_count(mispred_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecCount++;
      if (obs !== exp) begin
         errCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic goIdle();
      id_valid = 1'b0; id_branch = 1'b0; rs1_fwd = 2'b00; rs2_fwd = 2'b00;
      ex_is_load = 1'b0; id_pred_taken = 1'b0; funct3 = 3'b000;
   endtask

   task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] imm, input logic [2:0] f3,
                                input logic [31:0] r1, input logic [31:0] r2, input logic pred);
      id_valid = 1'b1; id_branch = 1'b1; id_pc = pc; id_imm = imm; funct3 = f3;
      rs1_data = r1; rs2_data = r2; id_pred_taken = pred;
      rs1_fwd = 2'b00; rs2_fwd = 2'b00; ex_is_load = 1'b0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic checkCounters(input string tag);
      checkOutput({tag, "_br"}, br_count, expBr);
      checkOutput({tag, "_mis"}, mispred_count, expMis);
   endtask

   logic [2:0]  condF3 [6]  = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b001, 3'b000};
   logic        condTkn [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

   initial begin
      rst_n = 1'b0; if_pc = 32'h0; id_pc = 32'h0; id_imm = 32'h0;
      rs1_data = 32'h0; rs2_data = 32'h0; ex_result = 32'h0; mem_result = 32'h0;
      wb_result = 32'h0;
      goIdle();
      #12;
      checkOutput("rst_redirect_valid", redirect_valid, 1'b0);
      checkOutput("rst_redirect_pc", redirect_pc, 32'h0);
      checkOutput("rst_illegal", illegal_branch, 1'b0);
      checkCounters("rst");
      checkOutput("rst_bht0", dut.bht[0], 2'b01);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      // BHT training on index 0
      if_pc = 32'h40;
      applyStimulus(32'h40, 32'h10, 3'b000, 32'd5, 32'd5, 1'b0);
      #1;
      checkOutput("train_pred_before", if_pred_taken, 1'b0);
      checkOutput("train_stall", stall, 1'b0);
      step(); expBr++; expMis++;
      checkOutput("train_redirect_valid", redirect_valid, 1'b1);
      checkOutput("train_redirect_pc", redirect_pc, 32'h50);
      checkOutput("train_bht0_10", dut.bht[0], 2'b10);
      checkCounters("train1");
      goIdle();
      step();
      checkOutput("train_redirect_drop", redirect_valid, 1'b0);
      checkOutput("train_redirect_pc_hold", redirect_pc, 32'h50);
      applyStimulus(32'h40, 32'h10, 3'b000, 32'd5, 32'd5, 1'b1);
      step(); expBr++;
      checkOutput("train2_no_redirect", redirect_valid, 1'b0);
      checkOutput("train2_bht0_11", dut.bht[0], 2'b11);
      checkOutput("train2_pred_after", if_pred_taken, 1'b1);
      step(); expBr++;
      step(); expBr++;
      checkOutput("train_sat_bht0_11", dut.bht[0], 2'b11);
      checkCounters("train4");
      goIdle();
      step();

      // Condition matrix on rs1=-1, rs2=1, all predicted not taken
      for (int i = 0; i < 6; i++) begin
         applyStimulus(32'h104, 32'h20, condF3[i], 32'hFFFF_FFFF, 32'h1, 1'b0);
         step(); expBr++;
         if (condTkn[i]) expMis++;
         checkOutput($sformatf("cond%0d_redirect", condF3[i]), redirect_valid, condTkn[i]);
         if (condTkn[i]) checkOutput($sformatf("cond%0d_pc", condF3[i]), redirect_pc, 32'h124);
         goIdle();
         step();
      end
      checkCounters("cond");
      applyStimulus(32'h104, 32'h20, 3'b110, 32'hFFFF_FFFF, 32'h1, 1'b1);
      step(); expBr++; expMis++;
      checkOutput("bltu_pred1_redirect", redirect_valid, 1'b1);
      checkOutput("bltu_pred1_fallthru", redirect_pc, 32'h108);
      goIdle();
      step();

      // Load-use stall then forwarded resolve
      applyStimulus(32'h200, 32'h40, 3'b000, 32'hDEAD, 32'd7, 1'b0);
      rs1_fwd = 2'b01; ex_is_load = 1'b1; ex_result = 32'h99;
      #1;
      checkOutput("loaduse_stall", stall, 1'b1);
      step();
      checkCounters("loaduse_hold");
      checkOutput("loaduse_no_redirect", redirect_valid, 1'b0);
      ex_is_load = 1'b0; rs1_fwd = 2'b10; mem_result = 32'd7;
      #1;
      checkOutput("loaduse_release", stall, 1'b0);
      step(); expBr++; expMis++;
      checkOutput("loaduse_redirect_pc", redirect_pc, 32'h240);
      checkCounters("loaduse_resolve");
      goIdle();
      step();

      // Squash during redirect, then PC wrap
      applyStimulus(32'h300, 32'h8, 3'b000, 32'd3, 32'd3, 1'b0);
      step(); expBr++; expMis++;
      checkOutput("squash_setup", redirect_valid, 1'b1);
      applyStimulus(32'h0C, 32'h8, 3'b000, 32'd3, 32'd3, 1'b0);
      rs1_fwd = 2'b01; ex_is_load = 1'b1; ex_result = 32'd3;
      #1;
      checkOutput("squash_no_stall", stall, 1'b0);
      step();
      checkCounters("squash");
      checkOutput("squash_no_redirect", redirect_valid, 1'b0);
      checkOutput("squash_bht3", dut.bht[3], 2'b01);
      applyStimulus(32'hFFFF_FFFC, 32'h8, 3'b000, 32'd1, 32'd1, 1'b0);
      step(); expBr++; expMis++;
      checkOutput("wrap_redirect_pc", redirect_pc, 32'h4);
      goIdle();
      step();

      // Illegal funct3, then same-index read/write collision
      applyStimulus(32'h20, 32'h8, 3'b010, 32'd1, 32'd1, 1'b0);
      step(); expBr++;
      checkOutput("illegal_flag", illegal_branch, 1'b1);
      checkOutput("illegal_no_redirect", redirect_valid, 1'b0);
      checkOutput("illegal_bht8", dut.bht[8], 2'b01);
      checkCounters("illegal");
      goIdle();
      step();
      checkOutput("illegal_pulse_end", illegal_branch, 1'b0);
      if_pc = 32'h20;
      applyStimulus(32'h20, 32'h8, 3'b000, 32'd1, 32'd1, 1'b0);
      #1;
      checkOutput("collide_old_value", if_pred_taken, 1'b0);
      step(); expBr++; expMis++;
      checkOutput("collide_new_value", if_pred_taken, 1'b1);
      checkOutput("collide_redirect_pc", redirect_pc, 32'h28);

      // Asynchronous reset while a redirect is pending
      goIdle();
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("arst_redirect_valid", redirect_valid, 1'b0);
      checkOutput("arst_redirect_pc", redirect_pc, 32'h0);
      expBr = 0; expMis = 0;
      checkCounters("arst");
      for (int i = 0; i < 16; i++) checkOutput($sformatf("arst_bht%0d", i), dut.bht[i], 2'b01);
      @(negedge clk);
      rst_n = 1'b1;
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vecCount, errCount);
      $finish;
   end

endmodule

// File: doc/id_branch_unit.md
Name: id_branch_unit

Overview:
- Decode-stage branch resolution unit for the 5-stage core.
- Selects forwarded operands from EX/MEM/WB and evaluates all six RV32 conditional branches.
- Owns a parametrised 2-bit branch history table (BHT) read in IF and trained in ID.
- Issues a registered redirect on misprediction, stalls on load-use hazards, and keeps branch/mispredict performance counters.

Parameters:
XLEN, 32, datapath/PC width
BHT_DEPTH, 16, number of 2-bit counters; power of two, >=2
CNT_W, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous reset, active low
if_pc  in  XLEN  IF-stage PC for BHT lookup
if_pred_taken  out  1  prediction for if_pc
id_valid  in  1  ID holds a valid instruction
id_branch  in  1  ID instruction is a conditional branch
id_pc  in  XLEN  PC of ID instruction
id_imm  in  XLEN  sign-extended B-immediate
id_pred_taken  in  1  prediction carried with the ID instruction
funct3  in  3  branch condition
rs1_data, rs2_data  in  XLEN  register-file read data
rs1_fwd, rs2_fwd  in  2  00 regfile, 01 EX, 10 MEM, 11 WB
ex_result, mem_result, wb_result  in  XLEN  forwarding sources
ex_is_load  in  1  EX instruction is a load
stall  out  1  hold IF/ID this cycle
redirect_valid  out  1  registered mispredict redirect
redirect_pc  out  XLEN  correct next PC
illegal_branch  out  1  registered, funct3 is 010/011 on a resolved branch
br_count  out  CNT_W  resolved branches
mispred_count  out  CNT_W  mispredicted branches

Behaviour:
- Reset (async, rst_n=0):
  - All BHT entries = 2'b01 (weakly not taken).
  - redirect_valid=0, redirect_pc=0, illegal_branch=0, br_count=0, mispred_count=0.
  - Deassertion is synchronised by the clock only; no other reset action.
- Operand select: per rs*_fwd, combinational; 01 selects ex_result.
- Hazard (combinational): stall=1 when id_valid & id_branch & ex_is_load & (rs1_fwd==01 | rs2_fwd==01) & !redirect_valid.
- Squash: when redirect_valid=1, the ID instruction is wrong-path. It is neither resolved nor counted, stall=0, and the BHT is not written.
- Resolve condition: id_valid & id_branch & !stall & !redirect_valid.
- Branch conditions:
  - BEQ 000 eq; BNE 001 ne; BLT 100 signed lt; BGE 101 signed ge; BLTU 110 unsigned lt; BGEU 111 unsigned ge.
  - 010/011: taken=0, illegal_branch=1 next cycle, no BHT update, still counted in br_count.
- Target: id_pc+id_imm, mod 2^XLEN (wraps). Fall-through: id_pc+4, wraps.
- Mispredict: resolve & (taken != id_pred_taken).
  - Next edge: redirect_valid=1, redirect_pc = taken ? target : fall-through.
  - Otherwise redirect_valid=0 next edge; redirect_pc holds its last value.
  - Pulse lasts exactly one cycle; back-to-back mispredicts cannot occur because of the squash rule.
- BHT:
  - Index = pc[$clog2(BHT_DEPTH)+1:2].
  - if_pred_taken = bht[idx(if_pc)][1], combinational.
  - On a resolving legal branch, bht[idx(id_pc)] increments if taken and decrements if not, saturating at 00/11, written at the clock edge.
  - Same-cycle read and write of the same index: read returns the old value.
- Counters, updated at the edge on resolve:
  - br_count += 1.
  - mispred_count += 1 on mispredict.
  - Both saturate at all-ones.
- Stall cycles: no state change. The same branch is re-presented next cycle and resolves once.
- Reset asserted mid-operation clears a pending redirect immediately (asynchronously).

Test Plan:
- BHT training: BEQ at id_pc=0x40, rs1=rs2=5, id_pred_taken=0, id_imm=0x10 -> next cycle redirect_valid=1, redirect_pc=0x50, bht[0]=10, br_count=1, mispred_count=1. Repeat with pred=1 -> no redirect, bht[0]=11. Two more taken -> stays 11.
- Condition matrix: rs1=0xFFFFFFFF, rs2=1 -> BLT taken, BLTU not taken, BGE not taken, BGEU taken, BNE taken. Each with pred=0 gives redirect only when taken; redirect_pc=id_pc+4 when not taken and pred=1.
- Load-use: rs1_fwd=01, ex_is_load=1 -> stall=1 and counters unchanged. Next cycle ex_is_load=0, rs1_fwd=10, mem_result equal to rs2 on BEQ -> resolves exactly once, br_count +1.
- Squash and wrap: mispredict, then a branch presented during redirect_valid=1 -> not counted, no BHT write. id_pc=0xFFFFFFFC, id_imm=8, taken -> redirect_pc=0x00000004.
- Illegal/collision: funct3=010 -> illegal_branch=1 one cycle, no redirect, BHT unchanged. if_pc and id_pc mapping to the same index in one cycle -> if_pred_taken reflects the pre-update value.
- Reset mid-flight: assert rst_n=0 in the cycle redirect_valid=1 -> outputs clear without waiting for a clock edge; all BHT entries read 01 afterwards.
